xpb_accum_ctrl: RTL and testbench

XPB_ACCUM_CTRL -- requirements
Module: xpb_accum_ctrl

---
 rtl/xpb_accum_ctrl_if.sv | 40 ++++
 rtl/xpb_accum_ctrl.sv | 123 ++++++++++++
 tb/tb_xpb_accum_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/xpb_accum_ctrl_if.sv
// Bundles the job, lookup-table and result signals of xpb_accum_ctrl.
//
// Handshake semantics: a transfer on the job channel (in_valid/in_ready) or
// result channel (out_valid/out_ready) happens on a rising clock edge where
// both valid and ready are 1. The producer keeps valid and its data stable
// until that edge, and valid never depends combinationally on ready.
// The lookup side has no back-pressure: every lut_en cycle is a request,
// and lut_data answers it exactly one cycle later.
interface xpb_accum_ctrl_if #(
    parameter int DIG_W = 5,
    parameter int NSEG  = 8,
    parameter int VAL_W = 1024,
    parameter int ACC_W = 1028,
    parameter int SEL_W = $clog2(NSEG)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NSEG*DIG_W-1:0]   in_digits;
    logic                    lut_en;
    logic [SEL_W-1:0]        lut_sel;
    logic [DIG_W-1:0]        lut_digit;
    logic [VAL_W-1:0]        lut_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [ACC_W-1:0]        out_sum;
    logic                    busy;
    logic [1:0]              fsm_state;   // debug view of the controller state

    // Seen from the accumulator controller.
    modport slave (
        input  in_valid, in_digits, lut_data, out_ready,
        output in_ready, lut_en, lut_sel, lut_digit, out_valid, out_sum, busy, fsm_state
    );

    // Seen from the job source / table / result consumer.
    modport master (
        output in_valid, in_digits, lut_data, out_ready,
        input  in_ready, lut_en, lut_sel, lut_digit, out_valid, out_sum, busy, fsm_state
    );
endinterface

// File: rtl/xpb_accum_ctrl.sv
// xpb accumulation controller: takes a job of NSEG digits, issues one table
// lookup per digit on consecutive cycles, sums the returned values into a
// wide accumulator and presents the total on a valid/ready result port.
module xpb_accum_ctrl #(
    parameter int DIG_W = 5,
    parameter int NSEG  = 8,
    parameter int VAL_W = 1024,
    parameter int ACC_W = 1028,
    parameter int SEL_W = $clog2(NSEG)
) (
    input  logic                clk,
    input  logic                reset,
    xpb_accum_ctrl_if.slave     bus
);

    // The accumulator must hold NSEG full-scale values without wrapping.
    if (ACC_W < VAL_W + $clog2(NSEG)) begin : g_bad_acc_w
        $error("xpb_accum_ctrl: ACC_W too narrow for NSEG values of VAL_W bits");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state;
    logic [SEL_W-1:0]       cnt;
    logic [SEL_W-1:0]       cnt_nxt;
    logic [NSEG*DIG_W-1:0]  digits;
    logic [DIG_W-1:0]       digit_nxt;
    logic                   dly;        // lut_en delayed by one: lut_data is valid now
    logic [ACC_W-1:0]       acc;

    logic                   lut_en_q;
    logic [SEL_W-1:0]       lut_sel_q;
    logic [DIG_W-1:0]       lut_digit_q;
    logic                   out_valid_q;
    logic                   busy_q;
    logic                   in_ready_q;

    // Next segment index and the captured digit it addresses.
    assign cnt_nxt   = cnt + SEL_W'(1);
    assign digit_nxt = digits[cnt_nxt*DIG_W +: DIG_W];

    // Controller FSM, request pipeline and accumulator; all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            digits      <= '0;
            dly         <= 1'b0;
            acc         <= '0;
            lut_en_q    <= 1'b0;
            lut_sel_q   <= '0;
            lut_digit_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            // A request issued last cycle returns its value now; wrapping add.
            dly <= lut_en_q;
            if (dly) begin
                acc <= acc + ACC_W'(bus.lut_data);
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        digits      <= bus.in_digits;
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= ISSUE;
                        lut_en_q    <= 1'b1;
                        lut_sel_q   <= '0;
                        lut_digit_q <= bus.in_digits[DIG_W-1:0];
                        in_ready_q  <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (cnt == SEL_W'(NSEG - 1)) begin
                        // Last request is on the bus this cycle; wait for its data.
                        state       <= DRAIN;
                        lut_en_q    <= 1'b0;
                        lut_sel_q   <= '0;
                        lut_digit_q <= '0;
                    end else begin
                        cnt         <= cnt_nxt;
                        lut_sel_q   <= cnt_nxt;
                        lut_digit_q <= digit_nxt;
                    end
                end
                DRAIN: begin
                    state       <= DONE;
                    out_valid_q <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.lut_en    = lut_en_q;
    assign bus.lut_sel   = lut_sel_q;
    assign bus.lut_digit = lut_digit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = acc;
    assign bus.busy      = busy_q;
    assign bus.fsm_state = state;

endmodule

// File: tb/tb_xpb_accum_ctrl.sv
// Directed bench for xpb_accum_ctrl with a 1-cycle stub lookup table
// returning (lut_sel+1)*lut_digit, or all ones when stub_full is set.
module tb_xpb_accum_ctrl;
    localparam int DIG_W = 5;
    localparam int NSEG  = 8;
    localparam int VAL_W = 1024;
    localparam int ACC_W = 1028;
    localparam int SEL_W = 3;
    localparam int DW    = NSEG * DIG_W;

    logic clk;
    logic reset;
    logic stub_full;
    int   total;
    int   bad;

    logic [ACC_W-1:0] exp_q[$];

    xpb_accum_ctrl_if #(.DIG_W(DIG_W), .NSEG(NSEG), .VAL_W(VAL_W), .ACC_W(ACC_W), .SEL_W(SEL_W)) bus ();

    xpb_accum_ctrl #(.DIG_W(DIG_W), .NSEG(NSEG), .VAL_W(VAL_W), .ACC_W(ACC_W), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // stub table, one cycle of latency
    always @(posedge clk) begin
        if (bus.lut_en) begin
            if (stub_full) bus.lut_data <= '1;
            else bus.lut_data <= VAL_W'((32'(bus.lut_sel) + 32'd1) * 32'(bus.lut_digit));
        end
    end

    task automatic check(input string tag, input logic [ACC_W-1:0] got, input logic [ACC_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got_hi=%0h got_lo=%0h exp_hi=%0h exp_lo=%0h", tag,
                     got[ACC_W-1:ACC_W-64], got[63:0], exp[ACC_W-1:ACC_W-64], exp[63:0]);
        end
    endtask

    // Offer one job, trace the request burst, check latency, result and
    // optional back-pressure in DONE, then release the result.
    task automatic run_job(input string tag, input logic [DW-1:0] dig,
                           input logic [ACC_W-1:0] exp, input int hold);
        int lat;
        bus.in_digits = dig;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        lat = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.out_valid) break;
            if (c < NSEG) begin
                check({tag, "_lut_en"},    ACC_W'(bus.lut_en), ACC_W'(1));
                check({tag, "_lut_sel"},   ACC_W'(bus.lut_sel), ACC_W'(c));
                check({tag, "_lut_digit"}, ACC_W'(bus.lut_digit), ACC_W'(dig[c*DIG_W +: DIG_W]));
            end else if (c == NSEG) begin
                check({tag, "_drain_lut_en"}, ACC_W'(bus.lut_en), ACC_W'(0));
                check({tag, "_drain_busy"},   ACC_W'(bus.busy), ACC_W'(1));
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, ACC_W'(lat), ACC_W'(NSEG + 1));
        check({tag, "_sum"}, bus.out_sum, exp);
        check({tag, "_done_in_ready"}, ACC_W'(bus.in_ready), ACC_W'(0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, ACC_W'(bus.out_valid), ACC_W'(1));
            check({tag, "_hold_sum"}, bus.out_sum, exp);
            check({tag, "_hold_in_ready"}, ACC_W'(bus.in_ready), ACC_W'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, ACC_W'(bus.in_ready), ACC_W'(1));
        check({tag, "_idle_valid"}, ACC_W'(bus.out_valid), ACC_W'(0));
        check({tag, "_idle_busy"}, ACC_W'(bus.busy), ACC_W'(0));
    endtask

    initial begin
        logic [DW-1:0]    job_dig[3];
        logic [ACC_W-1:0] job_exp[3];
        logic [ACC_W-1:0] big;
        logic [ACC_W-1:0] one;
        int njob;
        int nres;
        int last;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        stub_full = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_digits = '0;
        bus.out_ready = 1'b0;
        bus.lut_data  = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  ACC_W'(bus.in_ready), ACC_W'(1));
        check("rst_busy",      ACC_W'(bus.busy), ACC_W'(0));
        check("rst_out_valid", ACC_W'(bus.out_valid), ACC_W'(0));
        check("rst_lut_en",    ACC_W'(bus.lut_en), ACC_W'(0));
        check("rst_sum",       bus.out_sum, ACC_W'(0));
        check("rst_state",     ACC_W'(bus.fsm_state), ACC_W'(0));
        reset = 1'b0;

        // all-zero digits: still eight requests, sum 0
        run_job("zero", {NSEG{5'd0}}, ACC_W'(0), 0);

        // all digits 31: 31*(1+...+8) = 1116
        run_job("max", {NSEG{5'h1f}}, ACC_W'(1116), 0);

        // result held under back-pressure, digits 1: 1+...+8 = 36
        run_job("hold", {NSEG{5'd1}}, ACC_W'(36), 20);

        // reset in the 4th ISSUE cycle
        bus.in_digits = {NSEG{5'h1f}};
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_lut_en",  ACC_W'(bus.lut_en), ACC_W'(1));
        check("mid_lut_sel", ACC_W'(bus.lut_sel), ACC_W'(3));
        reset = 1'b1;
        #1;
        check("mid_rst_lut_en",   ACC_W'(bus.lut_en), ACC_W'(0));
        check("mid_rst_sum",      bus.out_sum, ACC_W'(0));
        check("mid_rst_in_ready", ACC_W'(bus.in_ready), ACC_W'(1));
        check("mid_rst_busy",     ACC_W'(bus.busy), ACC_W'(0));
        check("mid_rst_valid",    ACC_W'(bus.out_valid), ACC_W'(0));
        check("mid_rst_state",    ACC_W'(bus.fsm_state), ACC_W'(0));
        #2;
        reset = 1'b0;
        // digits 0..7: sum of (i+1)*i = 168, accepted on first edge after reset
        run_job("post_rst", {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0}, ACC_W'(168), 0);

        // full-scale table values: 8*(2^1024-1) = 2^1027 - 8, no wrap
        stub_full = 1'b1;
        one = ACC_W'(1);
        big = (one << 1027) - ACC_W'(8);
        run_job("ones", {NSEG{5'd0}}, big, 0);
        check("ones_top_nibble", ACC_W'(bus.out_sum[ACC_W-1:VAL_W]), ACC_W'(4'h7));
        stub_full = 1'b0;

        // back-to-back jobs with in_valid held high
        job_dig[0] = {NSEG{5'd1}};
        job_exp[0] = ACC_W'(36);
        job_dig[1] = {NSEG{5'd2}};
        job_exp[1] = ACC_W'(72);
        job_dig[2] = {5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};
        job_exp[2] = ACC_W'(168);
        njob = 0;
        nres = 0;
        last = -1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int cyc = 0; cyc < 100 && nres < 3; cyc++) begin
            if (njob == 3 && !bus.in_ready) bus.in_valid = 1'b0;
            if (bus.in_ready && njob < 3) begin
                if (last >= 0) check("cont_spacing", ACC_W'(cyc - last), ACC_W'(NSEG + 3));
                last = cyc;
                bus.in_digits = job_dig[njob];
                exp_q.push_back(job_exp[njob]);
                njob++;
            end
            if (bus.out_valid) begin
                if (exp_q.size() > 0) check("cont_sum", bus.out_sum, exp_q.pop_front());
                else check("cont_unexpected", ACC_W'(1), ACC_W'(0));
                nres++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("cont_results", ACC_W'(nres), ACC_W'(3));
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("cont_end_in_ready", ACC_W'(bus.in_ready), ACC_W'(1));
        check("cont_end_busy", ACC_W'(bus.busy), ACC_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
